axis_noc_packetizer: RTL and testbench

Single-clock AXI-Stream to NoC packetizer for network interface injection paths. It accepts AXI-Stream beats of a configurable width and serialises each beat into an integer number of flits. Each packet gets a header flit, and frames longer than a configurable maximum are split into several packets. The virtual network is selected per packet from TID, and broadcast is flagged from TDEST. It replaces the byte-downsizer plus packet-creator chain, with no intermediate byte path.

---
 rtl/axis_noc_packetizer_if.sv | 38 +++
 rtl/axis_noc_packetizer.sv | 163 ++++++++++++++++
 tb/tb_axis_noc_packetizer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_noc_packetizer_if.sv
// Bundles the AXI-Stream ingress and NoC flit egress of the packetizer.
// The slave modport is the packetizer's view; master is the surrounding environment.
interface axis_noc_packetizer_if #(
    parameter int TDATA_W = 64,
    parameter int TID_W   = 4,
    parameter int TDEST_W = 8,
    parameter int FLIT_W  = 32,
    parameter int VC_W    = 1
) ();
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [TDATA_W-1:0] s_axis_tdata;
    logic               s_axis_tlast;
    logic [TID_W-1:0]   s_axis_tid;
    logic [TDEST_W-1:0] s_axis_tdest;
    logic               network_valid;
    logic               network_ready;
    logic [FLIT_W-1:0]  network_flit;
    logic [1:0]         network_flit_type;
    logic               network_broadcast;
    logic [VC_W-1:0]    network_virtual_channel_id;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tid, s_axis_tdest,
        input  network_ready,
        output s_axis_tready,
        output network_valid, network_flit, network_flit_type,
        output network_broadcast, network_virtual_channel_id
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tid, s_axis_tdest,
        output network_ready,
        input  s_axis_tready,
        input  network_valid, network_flit, network_flit_type,
        input  network_broadcast, network_virtual_channel_id
    );
endinterface

// File: rtl/axis_noc_packetizer.sv
// AXI-Stream to NoC packetizer: each beat becomes Ratio payload flits, each packet gets
// a header flit, and frames longer than MaxBeatsPerPacket beats are split into packets.
module axis_noc_packetizer #(
    parameter int AxiStreamIfTDataWidth            = 64,
    parameter int AxiStreamIfTIdWidth              = 4,
    parameter int AxiStreamIfTDestWidth            = 8,
    parameter int NetworkIfAddressId               = 0,
    parameter int NetworkIfAddressIdWidth          = 8,
    parameter int NetworkIfNumberOfVirtualNetworks = 2,
    parameter int NetworkIfVirtualChannelIdWidth   = 1,
    parameter int NetworkIfFlitWidth               = 32,
    parameter int MaxBeatsPerPacket                = 4
) (
    input logic                  clk_axis_i,
    input logic                  rst_axis_ni,
    axis_noc_packetizer_if.slave bus
);
    localparam int RATIO = AxiStreamIfTDataWidth / NetworkIfFlitWidth;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CNT_W = $clog2(MaxBeatsPerPacket + 1);
    localparam int HDR_W = AxiStreamIfTDestWidth + NetworkIfAddressIdWidth + AxiStreamIfTIdWidth;
    localparam int VC_W  = NetworkIfVirtualChannelIdWidth;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MaxBeatsPerPacket);
    localparam logic [NetworkIfAddressIdWidth-1:0] SRC_ID = NetworkIfAddressIdWidth'(NetworkIfAddressId);

    typedef enum logic [1:0] {IDLE, HEAD, BODY, WAIT} state_e;

    state_e                             state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [AxiStreamIfTDataWidth-1:0]   data_q, data_d;
    logic                               last_q, last_d;
    logic [AxiStreamIfTIdWidth-1:0]     tid_q, tid_d;
    logic [AxiStreamIfTDestWidth-1:0]   tdest_q, tdest_d;
    logic [VC_W-1:0]                    vc_q, vc_d;
    logic                               bc_q, bc_d;
    logic                               ready_en_q;

    logic                               final_flit, closing, tready, accept;
    logic [NetworkIfFlitWidth-1:0]      hdr;
    logic [RATIO-1:0][NetworkIfFlitWidth-1:0] beat_flits;

    always_ff @(posedge clk_axis_i or negedge rst_axis_ni) begin
        if (!rst_axis_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            tid_q      <= '0;
            tdest_q    <= '0;
            vc_q       <= '0;
            bc_q       <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            last_q     <= last_d;
            tid_q      <= tid_d;
            tdest_q    <= tdest_d;
            vc_q       <= vc_d;
            bc_q       <= bc_d;
            ready_en_q <= 1'b1;
        end
    end

    assign final_flit = (state_q == BODY) && (idx_q == IDX_LAST);
    assign closing    = last_q || (cnt_q == CNT_MAX);
    assign tready     = ready_en_q && ((state_q == IDLE) || (state_q == WAIT) ||
                                       (final_flit && bus.network_ready));
    assign accept     = bus.s_axis_tvalid && tready;
    assign bus.s_axis_tready = tready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        tid_d   = tid_q;
        tdest_d = tdest_q;
        vc_d    = vc_q;
        bc_d    = bc_q;
        // The buffer can only accept when it is empty or its last flit is leaving.
        if (accept) begin
            data_d  = bus.s_axis_tdata;
            last_d  = bus.s_axis_tlast;
            tid_d   = bus.s_axis_tid;
            tdest_d = bus.s_axis_tdest;
        end
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = HEAD;
                cnt_d   = CNT_W'(1);
                vc_d    = VC_W'(32'(bus.s_axis_tid) % NetworkIfNumberOfVirtualNetworks);
                bc_d    = &bus.s_axis_tdest;
            end
            HEAD: if (bus.network_ready) begin
                state_d = BODY;
                idx_d   = '0;
            end
            BODY: if (bus.network_ready) begin
                if (!final_flit) begin
                    idx_d = idx_q + IDX_W'(1);
                end else if (closing) begin
                    idx_d = '0;
                    if (accept) begin
                        state_d = HEAD;
                        cnt_d   = CNT_W'(1);
                        vc_d    = VC_W'(32'(bus.s_axis_tid) % NetworkIfNumberOfVirtualNetworks);
                        bc_d    = &bus.s_axis_tdest;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (accept) begin
                    idx_d = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = WAIT;
                    idx_d   = '0;
                end
            end
            WAIT: if (accept) begin
                state_d = BODY;
                idx_d   = '0;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign beat_flits = data_q;

    always_comb begin
        hdr = '0;
        hdr[HDR_W-1:0] = {tid_q, SRC_ID, tdest_q};
    end

    always_comb begin
        bus.network_valid              = 1'b0;
        bus.network_flit               = '0;
        bus.network_flit_type          = 2'd0;
        bus.network_broadcast          = bc_q;
        bus.network_virtual_channel_id = vc_q;
        unique case (state_q)
            HEAD: begin
                bus.network_valid = 1'b1;
                bus.network_flit  = hdr;
            end
            BODY: begin
                bus.network_valid     = 1'b1;
                bus.network_flit      = beat_flits[idx_q];
                bus.network_flit_type = (final_flit && closing) ? (last_q ? 2'd3 : 2'd2) : 2'd1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axis_noc_packetizer.sv
// Directed bench: a table of single-beat frames plus hand-written multi-cycle sequences
// (packet splitting, stalls, source gap, mid-packet reset).
module tb_axis_noc_packetizer;
    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [3:0]  id;
        logic [7:0]  dest;
    } beat_t;

    typedef struct packed {
        logic [31:0] flit;
        logic [1:0]  ty;
        logic        vc;
        logic        bc;
    } flit_t;

    typedef struct packed {
        beat_t b;
        flit_t e0;
        flit_t e1;
        flit_t e2;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic rdy_toggle = 1'b0;

    flit_t got_q[$];
    int    got_cyc[$];
    flit_t exp_q[$];

    axis_noc_packetizer_if #(.TDATA_W(64), .TID_W(4), .TDEST_W(8), .FLIT_W(32), .VC_W(1)) ifc ();

    axis_noc_packetizer dut (
        .clk_axis_i (clk),
        .rst_axis_ni(rst_n),
        .bus        (ifc.slave)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Network ready driver: constant high, or toggling every cycle.
    initial begin
        ifc.network_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifc.network_ready = rdy_toggle ? ~ifc.network_ready : 1'b1;
        end
    end

    // Flit monitor plus stall-stability and tready-timing checks.
    initial begin
        flit_t cur, held;
        logic  stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cur = {ifc.network_flit, ifc.network_flit_type,
                       ifc.network_virtual_channel_id, ifc.network_broadcast};
                if (stalled && ifc.network_valid)
                    chk("stall_hold", 64'(cur), 64'(held));
                if (ifc.network_valid && ifc.network_ready) begin
                    got_q.push_back(cur);
                    got_cyc.push_back(cyc);
                end
                if (ifc.s_axis_tready && ifc.network_valid)
                    chk("tready_on_final_accept",
                        64'({ifc.network_ready, ifc.network_flit_type != 2'd0}), 64'(2'b11));
                stalled = ifc.network_valid && !ifc.network_ready;
                held    = cur;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send(input beat_t b, output int acc);
        ifc.s_axis_tvalid = 1'b1;
        ifc.s_axis_tdata  = b.data;
        ifc.s_axis_tlast  = b.last;
        ifc.s_axis_tid    = b.id;
        ifc.s_axis_tdest  = b.dest;
        acc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ifc.s_axis_tready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: got no tready expected acceptance within 200 cycles");
        end
        @(posedge clk);
        #1;
        ifc.s_axis_tvalid = 1'b0;
    endtask

    task automatic check_flits(input string name);
        int n;
        for (int k = 0; k < 500 && got_q.size() < exp_q.size(); k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk({name, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " valid"}, 64'(ifc.network_valid), 64'(0));
        chk({name, " flit"},  64'(ifc.network_flit), 64'(0));
        chk({name, " type"},  64'(ifc.network_flit_type), 64'(0));
        chk({name, " vc"},    64'(ifc.network_virtual_channel_id), 64'(0));
        chk({name, " bc"},    64'(ifc.network_broadcast), 64'(0));
        chk({name, " tready"}, 64'(ifc.s_axis_tready), 64'(0));
    endtask

    task automatic release_reset(input string name);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk({name, " tready_cycle1"}, 64'(ifc.s_axis_tready), 64'(0));
        @(negedge clk);
        chk({name, " tready_cycle2"}, 64'(ifc.s_axis_tready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t  tbl[5];
        beat_t b;
        int    acc, acc0, hdr_w;
        logic  ok;

        // {data, last, tid, tdest}, header, low flit, high flit ({flit, type, vc, bc})
        tbl[0] = '{'{64'h1122334455667788, 1'b1, 4'h3, 8'h05},
                   '{32'h00030005, 2'd0, 1'b1, 1'b0},
                   '{32'h55667788, 2'd1, 1'b1, 1'b0},
                   '{32'h11223344, 2'd3, 1'b1, 1'b0}};
        tbl[1] = '{'{64'hDEADBEEF01234567, 1'b1, 4'h2, 8'hFF},
                   '{32'h000200FF, 2'd0, 1'b0, 1'b1},
                   '{32'h01234567, 2'd1, 1'b0, 1'b1},
                   '{32'hDEADBEEF, 2'd3, 1'b0, 1'b1}};
        tbl[2] = '{'{64'h00000000FFFFFFFF, 1'b1, 4'h1, 8'h01},
                   '{32'h00010001, 2'd0, 1'b1, 1'b0},
                   '{32'hFFFFFFFF, 2'd1, 1'b1, 1'b0},
                   '{32'h00000000, 2'd3, 1'b1, 1'b0}};
        tbl[3] = '{'{64'h8000000100000080, 1'b1, 4'hF, 8'h80},
                   '{32'h000F0080, 2'd0, 1'b1, 1'b0},
                   '{32'h00000080, 2'd1, 1'b1, 1'b0},
                   '{32'h80000001, 2'd3, 1'b1, 1'b0}};
        tbl[4] = '{'{64'h0F0F0F0FF0F0F0F0, 1'b1, 4'h0, 8'h00},
                   '{32'h00000000, 2'd0, 1'b0, 1'b0},
                   '{32'hF0F0F0F0, 2'd1, 1'b0, 1'b0},
                   '{32'h0F0F0F0F, 2'd3, 1'b0, 1'b0}};

        ifc.s_axis_tvalid = 1'b0;
        ifc.s_axis_tdata  = '0;
        ifc.s_axis_tlast  = 1'b0;
        ifc.s_axis_tid    = '0;
        ifc.s_axis_tdest  = '0;

        // Reset state and tready release timing
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset("reset_release");

        // Single-beat frames, back to back (broadcast 0xFF followed by 0x01 included)
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tbl[i].e0);
            exp_q.push_back(tbl[i].e1);
            exp_q.push_back(tbl[i].e2);
        end
        acc0 = 0;
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].b, acc);
            if (i == 0) acc0 = acc;
        end
        check_flits("table");
        if (got_cyc.size() > 0)
            chk("header_latency", 64'(got_cyc[0] - acc0), 64'(1));
        chk("idle_tready", 64'(ifc.s_axis_tready), 64'(1));

        // 10-beat frame split into packets of 4, 4 and 2 beats
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        for (int k = 0; k < 10; k++) begin
            if (k % 4 == 0) exp_q.push_back('{32'h00050022, 2'd0, 1'b1, 1'b0});
            exp_q.push_back('{32'hA0000000 | 32'(k), 2'd1, 1'b1, 1'b0});
            exp_q.push_back('{32'hB0000000 | 32'(k), (k == 9) ? 2'd3 : (k % 4 == 3) ? 2'd2 : 2'd1,
                              1'b1, 1'b0});
        end
        for (int k = 0; k < 10; k++) begin
            b = '{{32'hB0000000 | 32'(k), 32'hA0000000 | 32'(k)}, (k == 9), 4'h5, 8'h22};
            send(b, acc);
        end
        check_flits("split");
        if (got_cyc.size() == exp_q.size())
            chk("split_gap_free", 64'(got_cyc[got_cyc.size()-1] - got_cyc[0]), 64'(exp_q.size() - 1));

        // 3-beat frame with network_ready toggling every cycle
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        rdy_toggle = 1'b1;
        exp_q.push_back('{32'h00060010, 2'd0, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{32'hD00D0000 | 32'(k), 2'd1, 1'b0, 1'b0});
            exp_q.push_back('{32'hCAFE0000 | 32'(k), (k == 2) ? 2'd3 : 2'd1, 1'b0, 1'b0});
        end
        for (int k = 0; k < 3; k++) begin
            b = '{{32'hCAFE0000 | 32'(k), 32'hD00D0000 | 32'(k)}, (k == 2), 4'h6, 8'h10};
            send(b, acc);
        end
        check_flits("toggle");
        rdy_toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Five-cycle source gap inside a frame: WAIT, no second header
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        exp_q.push_back('{32'h00010042, 2'd0, 1'b1, 1'b0});
        exp_q.push_back('{32'h00000001, 2'd1, 1'b1, 1'b0});
        exp_q.push_back('{32'h00000002, 2'd1, 1'b1, 1'b0});
        exp_q.push_back('{32'h00000003, 2'd1, 1'b1, 1'b0});
        exp_q.push_back('{32'h00000004, 2'd3, 1'b1, 1'b0});
        send('{64'h0000000200000001, 1'b0, 4'h1, 8'h42}, acc);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("gap_valid_low", 64'(ifc.network_valid), 64'(0));
        chk("gap_tready_high", 64'(ifc.s_axis_tready), 64'(1));
        @(posedge clk);
        #1;
        send('{64'h0000000400000003, 1'b1, 4'h1, 8'h42}, acc);
        check_flits("gap");

        // Reset pulse while a body flit is presented
        send('{64'h7777666655554444, 1'b1, 4'h3, 8'hFF}, acc);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifc.network_valid && ifc.network_flit_type == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("body_seen_before_reset", 64'(ok), 64'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        release_reset("mid_reset_release");
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        exp_q.push_back(tbl[0].e0);
        exp_q.push_back(tbl[0].e1);
        exp_q.push_back(tbl[0].e2);
        send(tbl[0].b, acc);
        check_flits("after_reset");

        hdr_w = n_vec;
        $display("== %0d vectors applied, %0d miscompares ==", hdr_w, n_bad);
        $finish;
    end
endmodule
